// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar serial transmitter: FSM state codes,
// ASCII constants of the "aaa,ddd#" frame and small character helpers.
package sonar_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        PREPARA = 4'h1,
        ENVIA   = 4'h2,
        ESPERA  = 4'h3,
        PROXIMO = 4'h4,
        FINAL   = 4'hF
    } estado_t;

    localparam logic [6:0]  ASCII_ZERO    = 7'h30;
    localparam logic [6:0]  ASCII_VIRGULA = 7'h2C;
    localparam logic [6:0]  ASCII_FIM     = 7'h23;
    localparam int unsigned FRAME_LEN     = 8;

    // Digits above 9 are deliberately not clamped.
    function automatic logic [6:0] digito_ascii(input logic [3:0] digito);
        return ASCII_ZERO + {3'b000, digito};
    endfunction

    function automatic logic paridade_impar(input logic [6:0] dados);
        return ~^dados;
    endfunction

endpackage

// File: rtl/tx_serial_7O1.sv
// UART transmitter for one 7O1 character: start, 7 data bits LSB first,
// odd parity, one stop bit, each held CLKS_PER_BIT clocks.
module tx_serial_7O1
    import sonar_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [6:0] dados_ascii,
    output logic       saida_serial,
    output logic       pronto
);

    localparam int unsigned CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_PENULT = CW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]    BIT_STOP    = 4'd9;

    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    shift_q, shift_d;
    logic          saida_q, saida_d;
    logic          ativo_q, ativo_d;
    logic          pronto_q, pronto_d;

    always_comb begin
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        saida_d  = saida_q;
        ativo_d  = ativo_q;
        pronto_d = 1'b0;
        if (partida && !ativo_q) begin
            shift_d = {1'b1, paridade_impar(dados_ascii), dados_ascii, 1'b0};
            saida_d = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
            ativo_d = 1'b1;
        end else if (ativo_q) begin
            // Done is raised during the final stop-bit cycle so the caller's
            // FSM can restart with exactly two idle cycles between characters.
            if (bit_q == BIT_STOP && baud_q == BAUD_PENULT) begin
                pronto_d = 1'b1;
            end
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                if (bit_q == BIT_STOP) begin
                    ativo_d = 1'b0;
                    saida_d = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[9:1]};
                    saida_d = shift_q[1];
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
            saida_q  <= 1'b1;
            ativo_q  <= 1'b0;
            pronto_q <= 1'b0;
        end else begin
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            saida_q  <= saida_d;
            ativo_q  <= ativo_d;
            pronto_q <= pronto_d;
        end
    end

    assign saida_serial = saida_q;
    assign pronto       = pronto_q;

endmodule

// File: rtl/sonar_transmissor.sv
// Sonar frame transmitter: latches angle/distance BCD digits on request and
// sends "aaa,ddd#" through the 7O1 serializer, reporting busy and done.
module sonar_transmissor
    import sonar_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       transmitir,
    input  logic [3:0] angulo2,
    input  logic [3:0] angulo1,
    input  logic [3:0] angulo0,
    input  logic [3:0] medida2,
    input  logic [3:0] medida1,
    input  logic [3:0] medida0,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam logic [2:0] IDX_ULTIMO = 3'(FRAME_LEN - 1);

    estado_t         estado_q, estado_d;
    logic [2:0]      idx_q, idx_d;
    logic [5:0][3:0] dig_q, dig_d;
    logic            ocupado_q, pronto_q;
    logic            partida;
    logic            tx_pronto;
    logic [6:0]      caractere;

    always_comb begin
        caractere = ASCII_FIM;
        case (idx_q)
            3'd0:    caractere = digito_ascii(dig_q[5]);
            3'd1:    caractere = digito_ascii(dig_q[4]);
            3'd2:    caractere = digito_ascii(dig_q[3]);
            3'd3:    caractere = ASCII_VIRGULA;
            3'd4:    caractere = digito_ascii(dig_q[2]);
            3'd5:    caractere = digito_ascii(dig_q[1]);
            3'd6:    caractere = digito_ascii(dig_q[0]);
            default: caractere = ASCII_FIM;
        endcase
    end

    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        dig_d    = dig_q;
        partida  = 1'b0;
        case (estado_q)
            INICIAL: begin
                // Digits are captured together with the accepted request, so
                // any change from the following cycle on cannot reach the frame.
                if (transmitir) begin
                    estado_d = PREPARA;
                    dig_d    = {angulo2, angulo1, angulo0, medida2, medida1, medida0};
                end
            end
            PREPARA: begin
                idx_d    = '0;
                estado_d = ENVIA;
            end
            ENVIA: begin
                partida  = 1'b1;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (tx_pronto) begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: begin
                idx_d    = idx_q + 3'd1;
                estado_d = (idx_q == IDX_ULTIMO) ? FINAL : ENVIA;
            end
            FINAL: begin
                estado_d = INICIAL;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    // Status outputs are registered one cycle behind the state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q  <= INICIAL;
            idx_q     <= '0;
            dig_q     <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            idx_q     <= idx_d;
            dig_q     <= dig_d;
            ocupado_q <= (estado_q != INICIAL);
            pronto_q  <= (estado_q == FINAL);
        end
    end

    tx_serial_7O1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clock       (clock),
        .reset       (reset),
        .partida     (partida),
        .dados_ascii (caractere),
        .saida_serial(saida_serial),
        .pronto      (tx_pronto)
    );

    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_sonar_transmissor.sv
// Self-checking bench for sonar_transmissor: decodes the serial line into a
// scoreboard of expected 7O1 characters and checks frame timing.
module tb_sonar_transmissor;

    localparam int unsigned N   = 4;
    localparam int          P   = 10 * N + 2;
    localparam int          LAT = 2 + 8 * P;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       transmitir = 1'b0;
    logic [3:0] angulo2 = '0, angulo1 = '0, angulo0 = '0;
    logic [3:0] medida2 = '0, medida1 = '0, medida0 = '0;
    logic       saida_serial, ocupado, pronto;
    logic [3:0] db_estado;

    sonar_transmissor #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .transmitir  (transmitir),
        .angulo2     (angulo2),
        .angulo1     (angulo1),
        .angulo0     (angulo0),
        .medida2     (medida2),
        .medida1     (medida1),
        .medida0     (medida0),
        .saida_serial(saida_serial),
        .ocupado     (ocupado),
        .pronto      (pronto),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int checks = 0;
    int errors = 0;
    bit ignorar = 1'b0;

    typedef struct {
        logic [3:0] a2, a1, a0, m2, m1, m0;
        logic [6:0] chars [8];
    } vec_t;

    typedef struct {
        logic [9:0] quadro;
        int         inicio;
    } esp_t;

    vec_t tab [4];
    esp_t exp_q [$];

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] req);
        checks++;
        if (atual !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, req, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] a2, a1, a0, m2, m1, m0,
                                input logic [55:0] cs);
        vec_t v;
        v.a2 = a2; v.a1 = a1; v.a0 = a0;
        v.m2 = m2; v.m1 = m1; v.m0 = m0;
        for (int i = 0; i < 8; i++) v.chars[i] = cs[55 - 7 * i -: 7];
        return v;
    endfunction

    task automatic set_digits(input vec_t v);
        angulo2 = v.a2; angulo1 = v.a1; angulo0 = v.a0;
        medida2 = v.m2; medida1 = v.m1; medida0 = v.m0;
    endtask

    task automatic push_frame(input vec_t v, input int k);
        for (int i = 0; i < 8; i++) begin
            esp_t       e;
            logic [6:0] c;
            c        = v.chars[i];
            e.quadro = {1'b1, ~^c, c, 1'b0};
            e.inicio = k + 2 + i * P;
            exp_q.push_back(e);
        end
    endtask

    // Leaves the bench at the falling edge of cycle k (the accept edge).
    task automatic start_frame(input vec_t v, input bit hold, output int k);
        @(negedge clock);
        set_digits(v);
        transmitir = 1'b1;
        k = cyc + 1;
        push_frame(v, k);
        @(negedge clock);
        if (!hold) transmitir = 1'b0;
        check("accept_state", {28'd0, db_estado}, 32'd1);
    endtask

    task automatic wait_pronto(input int k, input string nome);
        bit got = 1'b0;
        for (int t = 0; t < LAT + 20; t++) begin
            if (pronto === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check({nome, "_pronto_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            check({nome, "_pronto_cycle"}, cyc, k + LAT);
            check({nome, "_busy_at_pronto"}, {31'd0, ocupado}, 32'd1);
            @(negedge clock);
            check({nome, "_pronto_width"}, {31'd0, pronto}, 32'd0);
            check({nome, "_busy_after"}, {31'd0, ocupado}, 32'd0);
        end
        check({nome, "_frame_complete"}, exp_q.size(), 0);
    endtask

    // Line monitor: samples each bit on its first cycle and scores the character.
    initial begin
        logic [9:0] bits;
        int         s;
        esp_t       e;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && saida_serial === 1'b0) begin
                s       = cyc;
                bits    = '0;
                bits[0] = saida_serial;
                for (int j = 1; j < 10; j++) begin
                    repeat (N) @(negedge clock);
                    bits[j] = saida_serial;
                end
                if (!ignorar) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_char: got %03h expected none (start %0d)", bits, s);
                    end else begin
                        e = exp_q.pop_front();
                        check("char_bits", {22'd0, bits}, {22'd0, e.quadro});
                        check("char_start", s, e.inicio);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bad;
        tab[0] = mk(4'd0, 4'd9, 4'd0, 4'd0, 4'd4, 4'd5,
                    {7'h30, 7'h39, 7'h30, 7'h2C, 7'h30, 7'h34, 7'h35, 7'h23});
        tab[1] = mk(4'd1, 4'd8, 4'd0, 4'd2, 4'd0, 4'd0,
                    {7'h31, 7'h38, 7'h30, 7'h2C, 7'h32, 7'h30, 7'h30, 7'h23});
        tab[2] = mk(4'd0, 4'd4, 4'd5, 4'd0, 4'd0, 4'hC,
                    {7'h30, 7'h34, 7'h35, 7'h2C, 7'h30, 7'h30, 7'h3C, 7'h23});
        tab[3] = mk(4'd9, 4'd9, 4'd9, 4'hF, 4'hA, 4'd7,
                    {7'h39, 7'h39, 7'h39, 7'h2C, 7'h3F, 7'h3A, 7'h37, 7'h23});

        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_saida", {31'd0, saida_serial}, 32'd1);
        check("rst_ocupado", {31'd0, ocupado}, 32'd0);
        check("rst_pronto", {31'd0, pronto}, 32'd0);
        check("rst_estado", {28'd0, db_estado}, 32'd0);
        reset = 1'b1;

        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 || db_estado !== 4'd0)
                bad++;
        end
        check("idle_after_reset", bad, 0);

        for (int unsigned i = 0; i < 4; i++) begin
            start_frame(tab[i], 1'b0, k);
            wait_pronto(k, "table");
            repeat (5) @(negedge clock);
        end

        // Inputs change right after accept; the frame must keep the old digits.
        start_frame(tab[0], 1'b0, k);
        set_digits(tab[1]);
        wait_pronto(k, "latch");
        repeat (5) @(negedge clock);

        // Request held high: one frame per accept, re-accept right after pronto.
        start_frame(tab[3], 1'b1, k);
        wait_pronto(k, "hold1");
        k = k + LAT + 1;
        check("hold_reaccept_cycle", cyc, k);
        push_frame(tab[3], k);
        transmitir = 1'b0;
        wait_pronto(k, "hold2");
        bad = 0;
        repeat (60) begin
            @(negedge clock);
            if (ocupado !== 1'b0 || saida_serial !== 1'b1) bad++;
        end
        check("single_frame_per_accept", bad, 0);

        // Reset mid-frame aborts the transfer for good.
        start_frame(tab[0], 1'b0, k);
        while (cyc < k + 149) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_saida", {31'd0, saida_serial}, 32'd1);
        check("abort_ocupado", {31'd0, ocupado}, 32'd0);
        check("abort_estado", {28'd0, db_estado}, 32'd0);
        ignorar = 1'b1;
        exp_q.delete();
        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (pronto !== 1'b0 || ocupado !== 1'b0 || saida_serial !== 1'b1) bad++;
        end
        check("abort_stays_idle", bad, 0);
        ignorar = 1'b0;

        start_frame(tab[2], 1'b0, k);
        wait_pronto(k, "after_abort");
        repeat (5) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
